p_emap_gather: RTL and testbench

P_EMAP_GATHER -- requirements
Module: p_emap_gather

---
 rtl/p_emap_pkg.sv | 18 +
 rtl/p_mem_1r1w.sv | 31 +++
 rtl/p_emap_gather.sv | 177 +++++++++++++++++
 tb/tb_p_emap_gather.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/p_emap_pkg.sv
// Shared types and constants for the P-vector gather block.
// Holds the gather FSM state encoding and the column-list terminator value.
// No ports; imported by p_emap_gather and its memory sub-module.
package p_emap_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DRAIN  = 3'd2,
    S_HOLD   = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  // All-ones marks the end of a column list. Users replicate bit 0 to build
  // the terminator at whatever element width they are parameterised with.
  localparam logic [31:0] TERMINATOR = '1;

endpackage

// File: rtl/p_mem_1r1w.sv
// P-vector storage: synchronous 1-read/1-write RAM, read-first on collision.
// Latency: read data valid one cycle after re_i. Backpressure: none, always accepts.
// Ports: clk_i; re_i/raddr_i -> rdata_o; we_i/waddr_i/wdata_i write port. No reset.
module p_mem_1r1w
  import p_emap_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/p_emap_gather.sv
// Gathers P-memory words indexed by a packed column list into NO_OF_UNITS-lane beats.
// Latency: NO_OF_UNITS+2 cycles per beat with out_ready high; timing is data-independent.
// Backpressure: a beat is held in HOLD (out_valid, output_row stable) until out_ready.
// Ports: clk/reset; read_preprocess+col_nos+no_of_multiples start a run;
//   write_* load P-memory at any time; output_row/out_valid/out_ready carry beats;
//   busy (not idle), done (1-cycle end pulse), index_error (sticky per run).
module p_emap_gather
  import p_emap_pkg::*;
#(
  parameter int NO_OF_UNITS               = 8,
  parameter int ELEMENT_WIDTH             = 32,
  parameter int NO_OF_ELEMENTS_ON_COL_NOS = 20,
  parameter int MEM_DEPTH                 = 65536,
  localparam int ADDR_WIDTH               = $clog2(MEM_DEPTH)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           read_preprocess,
  input  logic [NO_OF_ELEMENTS_ON_COL_NOS*ELEMENT_WIDTH-1:0] col_nos,
  input  logic [31:0]                                    no_of_multiples,
  input  logic                                           write_enable,
  input  logic [ADDR_WIDTH-1:0]                          write_addr,
  input  logic [ELEMENT_WIDTH-1:0]                       write_data,
  input  logic                                           out_ready,
  output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]           output_row,
  output logic                                           out_valid,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           index_error
);

  localparam int NC = NO_OF_ELEMENTS_ON_COL_NOS;
  localparam int EW = ELEMENT_WIDTH;
  localparam int LW = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 1;
  localparam logic [EW-1:0] TERM_W = {EW{TERMINATOR[0]}};

  state_e                  state_q;
  logic [NC*EW-1:0]        col_q;
  logic [31:0]             mult_q;     // beats still to emit, including current
  logic [31:0]             base_q;     // entry index of lane 0 in current beat
  logic [LW-1:0]           lane_q;
  logic                    term_q;     // terminator seen earlier in this run
  logic                    err_q;
  logic                    valid_q, busy_q, done_q;
  logic [NO_OF_UNITS*EW-1:0] row_q;
  // A read issued last cycle whose data lands this cycle.
  logic                    pend_q;
  logic [LW-1:0]           pend_lane_q;
  logic                    pend_zero_q;

  logic [31:0]             idx;
  logic [EW-1:0]           entry;
  logic                    in_list, is_term, oor, zero_lane, rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [EW-1:0]           rd_data;

  always_comb begin
    idx     = base_q + 32'(lane_q);
    entry   = '0;
    in_list = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (idx == 32'(i)) begin
        entry   = col_q[(NC-1-i)*EW +: EW];
        in_list = 1'b1;
      end
    end
    is_term   = in_list && (entry == TERM_W);
    oor       = in_list && !is_term && ({1'b0, entry} >= (EW+1)'(MEM_DEPTH));
    // Zeroed lanes still spend their FETCH cycle; only the RAM read is dropped.
    zero_lane = term_q || !in_list || is_term || oor;
    rd_en     = (state_q == S_FETCH) && !zero_lane;
    rd_addr   = entry[ADDR_WIDTH-1:0];
  end

  p_mem_1r1w #(
    .DEPTH(MEM_DEPTH),
    .WIDTH(EW),
    .AW   (ADDR_WIDTH)
  ) u_mem (
    .clk_i  (clk),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .we_i   (write_enable),
    .waddr_i(write_addr),
    .wdata_i(write_data),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      mult_q      <= '0;
      base_q      <= '0;
      lane_q      <= '0;
      term_q      <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_q       <= '0;
      pend_q      <= 1'b0;
      pend_lane_q <= '0;
      pend_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= 1'b0;
      if (pend_q) begin
        row_q[(NO_OF_UNITS-1-int'(pend_lane_q))*EW +: EW] <= pend_zero_q ? '0 : rd_data;
      end
      case (state_q)
        S_IDLE: begin
          if (read_preprocess) begin
            col_q  <= col_nos;
            mult_q <= no_of_multiples;
            base_q <= '0;
            lane_q <= '0;
            term_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (no_of_multiples == 32'd0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          pend_q      <= 1'b1;
          pend_lane_q <= lane_q;
          pend_zero_q <= zero_lane;
          if (is_term) term_q <= 1'b1;
          if (oor && !term_q) err_q <= 1'b1;
          if (lane_q == LW'(NO_OF_UNITS-1)) begin
            lane_q  <= '0;
            state_q <= S_DRAIN;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
        S_DRAIN: begin
          state_q <= S_HOLD;
          valid_q <= 1'b1;
        end
        S_HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            base_q  <= base_q + 32'(NO_OF_UNITS);
            if (mult_q == 32'd1) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              mult_q  <= mult_q - 32'd1;
              state_q <= S_FETCH;
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign output_row  = row_q;
  assign out_valid   = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign index_error = err_q;

endmodule

// File: tb/tb_p_emap_gather.sv
// Directed bench for p_emap_gather at default parameters, mem[a]=a+1 for used addresses.
// Latency: checks beat timing in cycles counted from the start edge.
// Backpressure: exercises out_ready stall in HOLD.
module tb_p_emap_gather;
  localparam int NU = 8;
  localparam int EW = 32;
  localparam int NC = 20;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              read_preprocess = 1'b0;
  logic [NC*EW-1:0]  col_nos = '0;
  logic [31:0]       no_of_multiples = '0;
  logic              write_enable = 1'b0;
  logic [AW-1:0]     write_addr = '0;
  logic [EW-1:0]     write_data = '0;
  logic              out_ready = 1'b1;
  logic [NU*EW-1:0]  output_row;
  logic              out_valid, busy, done, index_error;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [EW-1:0]    ent [NC];
  logic [NU*EW-1:0] exp_row;

  p_emap_gather dut (
    .clk(clk), .reset(reset), .read_preprocess(read_preprocess), .col_nos(col_nos),
    .no_of_multiples(no_of_multiples), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .out_ready(out_ready), .output_row(output_row),
    .out_valid(out_valid), .busy(busy), .done(done), .index_error(index_error)
  );

  task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Column list used by most runs: 19 valid addresses then a terminator.
  task automatic set_base();
    for (int i = 0; i < NC - 1; i++) ent[i] = 32'h601B - 32'(i) * 32'h6D;
    ent[NC-1] = '1;
  endtask

  task automatic start(input int m);
    for (int i = 0; i < NC; i++) col_nos[(NC-1-i)*EW +: EW] = ent[i];
    no_of_multiples = 32'(m);
    read_preprocess = 1'b1;
    step();
    read_preprocess = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (!out_valid) chk_eq({tag, "_valid_timeout"}, 256'(out_valid), 256'(1));
  endtask

  // Expected beat b: entry e gives mem[e]=e+1 unless past the list, at/after
  // the terminator position term_at, or the out-of-range entry bad.
  task automatic mk_exp(input int b, input int term_at, input int bad);
    int e;
    exp_row = '0;
    for (int l = 0; l < NU; l++) begin
      e = b * NU + l;
      if (e < NC && e < term_at && e != bad)
        exp_row[(NU-1-l)*EW +: EW] = 32'h601C - 32'(e) * 32'h6D;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step(); step();
    chk_eq("rst_row", 256'(output_row), 256'(0));
    chk_eq("rst_valid", 256'(out_valid), 256'(0));
    chk_eq("rst_busy", 256'(busy), 256'(0));
    chk_eq("rst_done", 256'(done), 256'(0));
    chk_eq("rst_err", 256'(index_error), 256'(0));
    reset = 1'b0;

    // Preload used addresses with a+1 through the write port.
    set_base();
    write_enable = 1'b1;
    for (int i = 0; i < NC - 1; i++) begin
      write_addr = ent[i][AW-1:0];
      write_data = ent[i] + 32'd1;
      step();
    end
    write_enable = 1'b0;

    // Three beats, terminator at entry 19, out_ready high.
    start(3);
    chk_eq("s1_busy", 256'(busy), 256'(1));
    for (int b = 0; b < 3; b++) begin
      wait_valid("s1");
      chk_eq("s1_cyc", 256'(cyc), 256'(9 + 10 * b));
      mk_exp(b, 19, -1);
      chk_eq("s1_row", 256'(output_row), 256'(exp_row));
      step();
    end
    chk_eq("s1_accept_cyc", 256'(cyc), 256'(30));
    chk_eq("s1_done", 256'(done), 256'(1));
    chk_eq("s1_valid_off", 256'(out_valid), 256'(0));
    step();
    chk_eq("s1_done_off", 256'(done), 256'(0));
    chk_eq("s1_idle", 256'(busy), 256'(0));

    // Terminator at entry 2.
    set_base();
    ent[2] = '1;
    start(3);
    for (int b = 0; b < 3; b++) begin
      wait_valid("s2");
      mk_exp(b, 2, -1);
      chk_eq("s2_row", 256'(output_row), 256'(exp_row));
      step();
    end
    chk_eq("s2_done", 256'(done), 256'(1));
    step();

    // Stall beat 0 for 5 cycles; a start request during the stall is ignored.
    set_base();
    out_ready = 1'b0;
    start(2);
    wait_valid("s3");
    chk_eq("s3_cyc0", 256'(cyc), 256'(9));
    mk_exp(0, 19, -1);
    read_preprocess = 1'b1;
    no_of_multiples = 32'd0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_eq("s3_hold_row", 256'(output_row), 256'(exp_row));
      chk_eq("s3_hold_valid", 256'(out_valid), 256'(1));
    end
    read_preprocess = 1'b0;
    out_ready = 1'b1;
    step();
    chk_eq("s3_accept_cyc", 256'(cyc), 256'(15));
    wait_valid("s3");
    chk_eq("s3_cyc1", 256'(cyc), 256'(24));
    mk_exp(1, 19, -1);
    chk_eq("s3_row1", 256'(output_row), 256'(exp_row));
    step();
    chk_eq("s3_done", 256'(done), 256'(1));
    step();

    // Out-of-range index in entry 0, then a zero-beat run.
    set_base();
    ent[0] = 32'h0001_0000;
    start(1);
    wait_valid("s4");
    mk_exp(0, 19, 0);
    chk_eq("s4_row", 256'(output_row), 256'(exp_row));
    step();
    chk_eq("s4_done", 256'(done), 256'(1));
    chk_eq("s4_err", 256'(index_error), 256'(1));
    step();
    chk_eq("s4_err_sticky", 256'(index_error), 256'(1));
    start(0);
    chk_eq("s4z_done", 256'(done), 256'(1));
    chk_eq("s4z_valid", 256'(out_valid), 256'(0));
    chk_eq("s4z_err_clr", 256'(index_error), 256'(0));
    chk_eq("s4z_busy", 256'(busy), 256'(1));
    step();
    chk_eq("s4z_done_off", 256'(done), 256'(0));
    chk_eq("s4z_valid_off", 256'(out_valid), 256'(0));
    chk_eq("s4z_idle", 256'(busy), 256'(0));

    // Reset during the 3rd FETCH cycle of a run that already flagged an error.
    start(3);
    step();
    step();
    chk_eq("s5_err_pre", 256'(index_error), 256'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_eq("s5_row", 256'(output_row), 256'(0));
    chk_eq("s5_valid", 256'(out_valid), 256'(0));
    chk_eq("s5_busy", 256'(busy), 256'(0));
    chk_eq("s5_done", 256'(done), 256'(0));
    chk_eq("s5_err", 256'(index_error), 256'(0));
    set_base();
    start(1);
    wait_valid("s5");
    mk_exp(0, 19, -1);
    chk_eq("s5_mem_kept", 256'(output_row), 256'(exp_row));
    step();
    step();

    // Write mem[0x601B] in the same cycle lane 0 reads it.
    set_base();
    start(1);
    write_enable = 1'b1;
    write_addr   = 16'h601B;
    write_data   = 32'h0000_AAAA;
    step();
    write_enable = 1'b0;
    wait_valid("s6");
    mk_exp(0, 19, -1);
    chk_eq("s6_read_first", 256'(output_row), 256'(exp_row));
    step();
    step();
    start(1);
    wait_valid("s6b");
    mk_exp(0, 19, -1);
    exp_row[(NU-1)*EW +: EW] = 32'h0000_AAAA;
    chk_eq("s6_rerun", 256'(output_row), 256'(exp_row));
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
